// File: rtl/pack_i_data.sv
// Byte-stream to complex-sample packer: four link bytes per sample, rebuilt into
// sign-extended real/imaginary words and handed to the FFT input buffer.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | frame boundary; counters cleared, waiting for the first byte
// COLLECT | gathering b0..b3 of a sample; inter-byte gap timer running
// PUSH    | full sample held until the FFT input buffer takes it
module pack_i_data #(
  parameter int bit_width      = 28,
  parameter int n_points       = 256,
  parameter int timeout_cycles = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic [7:0]           data_in,
  input  logic                 ready_i,
  output logic [bit_width-1:0] data_re_o,
  output logic [bit_width-1:0] data_im_o,
  output logic                 valid_o,
  output logic                 done_o,
  output logic                 overrun_o,
  output logic                 timeout_o
);

  localparam int SAMPLE_W = $clog2(n_points);
  localparam int GAP_W    = $clog2(timeout_cycles + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] PUSH    = 2'd2;

  localparam logic [SAMPLE_W-1:0] LAST_SAMPLE = SAMPLE_W'(n_points - 1);
  localparam logic [GAP_W-1:0]    GAP_LIMIT   = GAP_W'(timeout_cycles - 1);

  logic [1:0]          state;
  logic [1:0]          byte_cnt;
  logic [SAMPLE_W-1:0] sample_cnt;
  logic [GAP_W-1:0]    gap_cnt;

  logic [7:0] re_b0;
  logic [7:0] im_b1;
  logic [7:0] re_b2;
  logic [7:0] im_b3;

  logic [bit_width-1:0] re_full;
  logic [bit_width-1:0] im_full;

  // Inverse of the output serializer: bytes land in [23:8], low byte zero,
  // upper bits replicate the top byte's sign.
  always_comb begin
    re_full       = {bit_width{re_b2[7]}};
    re_full[23:0] = {re_b2, re_b0, 8'h00};
    im_full       = {bit_width{im_b3[7]}};
    im_full[23:0] = {im_b3, im_b1, 8'h00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_cnt   <= 2'd0;
      sample_cnt <= '0;
      gap_cnt    <= '0;
      re_b0      <= 8'h00;
      im_b1      <= 8'h00;
      re_b2      <= 8'h00;
      im_b3      <= 8'h00;
      data_re_o  <= '0;
      data_im_o  <= '0;
      valid_o    <= 1'b0;
      done_o     <= 1'b0;
      overrun_o  <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      valid_o   <= 1'b0;
      done_o    <= 1'b0;
      timeout_o <= 1'b0;

      case (state)
        IDLE: begin
          byte_cnt   <= 2'd0;
          sample_cnt <= '0;
          gap_cnt    <= '0;
          if (en_i) begin
            re_b0    <= data_in;
            byte_cnt <= 2'd1;
            state    <= COLLECT;
          end
        end

        COLLECT: begin
          if (en_i) begin
            case (byte_cnt)
              2'd0:    re_b0 <= data_in;
              2'd1:    im_b1 <= data_in;
              2'd2:    re_b2 <= data_in;
              default: im_b3 <= data_in;
            endcase
            gap_cnt <= '0;
            if (byte_cnt == 2'd3) begin
              byte_cnt <= 2'd0;
              state    <= PUSH;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end else if (byte_cnt != 2'd0) begin
            // Gap timer only runs with a partial sample in hand.
            if (gap_cnt == GAP_LIMIT) begin
              byte_cnt  <= 2'd0;
              gap_cnt   <= '0;
              timeout_o <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
        end

        PUSH: begin
          if (en_i) begin
            overrun_o <= 1'b1;
          end
          if (ready_i) begin
            data_re_o <= re_full;
            data_im_o <= im_full;
            valid_o   <= 1'b1;
            if (sample_cnt == LAST_SAMPLE) begin
              done_o <= 1'b1;
              state  <= IDLE;
            end else begin
              sample_cnt <= sample_cnt + SAMPLE_W'(1);
              state      <= COLLECT;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pack_i_data.sv
// Directed bench for pack_i_data with a short frame and short gap timeout.
module tb_pack_i_data;

  localparam int BW = 28;
  localparam int NP = 4;
  localparam int TO = 8;

  logic          clk;
  logic          rst_n;
  logic          en_i;
  logic [7:0]    data_in;
  logic          ready_i;
  logic [BW-1:0] data_re_o;
  logic [BW-1:0] data_im_o;
  logic          valid_o;
  logic          done_o;
  logic          overrun_o;
  logic          timeout_o;

  int checks = 0;
  int errors = 0;

  int            log_n = 0;
  logic [BW-1:0] log_re [0:31];
  logic [BW-1:0] log_im [0:31];
  logic          log_done [0:31];
  int            n_timeout = 0;
  int            n_done = 0;

  pack_i_data #(
    .bit_width(BW),
    .n_points(NP),
    .timeout_cycles(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en_i(en_i),
    .data_in(data_in),
    .ready_i(ready_i),
    .data_re_o(data_re_o),
    .data_im_o(data_im_o),
    .valid_o(valid_o),
    .done_o(done_o),
    .overrun_o(overrun_o),
    .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid_o && log_n < 32) begin
      log_re[log_n]   = data_re_o;
      log_im[log_n]   = data_im_o;
      log_done[log_n] = done_o;
      log_n++;
    end
    if (timeout_o) n_timeout++;
    if (done_o) n_done++;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    en_i    = 1'b1;
    data_in = b;
    @(negedge clk);
    en_i    = 1'b0;
  endtask

  task automatic send_sample(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || done_o !== 1'b0 || timeout_o !== 1'b0 || overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b done=%b timeout=%b overrun=%b, required all 0",
               valid_o, done_o, timeout_o, overrun_o);
    end
    checks++;
    if (data_re_o !== '0 || data_im_o !== '0) begin
      errors++;
      $display("FAIL reset_data: re=%h im=%h, required 0", data_re_o, data_im_o);
    end
    checks++;
    if (dut.state !== 2'd0 || dut.sample_cnt !== '0 || dut.byte_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d sample_cnt=%0d byte_cnt=%0d, required 0",
               dut.state, dut.sample_cnt, dut.byte_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    ready_i = 1'b1;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h83);
    send_byte(8'h44);
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_early_valid: valid=%b, required 0", valid_o);
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL single_valid: valid=%b done=%b, required 1/0", valid_o, done_o);
    end
    checks++;
    if (data_re_o !== 28'hF831100) begin
      errors++;
      $display("FAIL single_re: got %h, required %h", data_re_o, 28'hF831100);
    end
    checks++;
    if (data_im_o !== 28'h0442200) begin
      errors++;
      $display("FAIL single_im: got %h, required %h", data_im_o, 28'h0442200);
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || data_re_o !== 28'hF831100) begin
      errors++;
      $display("FAIL single_pulse_hold: valid=%b re=%h, required 0/%h",
               valid_o, data_re_o, 28'hF831100);
    end
  endtask

  task automatic test_frame();
    int base;
    int done0;
    logic [7:0] b0, b1, b2, b3;
    do_reset();
    base  = log_n;
    done0 = n_done;
    for (int k = 0; k < NP; k++) begin
      b0 = 8'h10 + 8'(k);
      b1 = 8'h20 + 8'(k);
      b2 = 8'h30 + 8'(k);
      b3 = 8'h80 + 8'(k);
      send_sample(b0, b1, b2, b3);
    end
    @(negedge clk);
    checks++;
    if (log_n - base !== NP) begin
      errors++;
      $display("FAIL frame_count: got %0d valid pulses, required %0d", log_n - base, NP);
    end
    checks++;
    if (n_done - done0 !== 1 || log_done[base + NP - 1] !== 1'b1) begin
      errors++;
      $display("FAIL frame_done: done pulses=%0d on_last=%b, required 1/1",
               n_done - done0, log_done[base + NP - 1]);
    end
    for (int k = 0; k < NP; k++) begin
      b0 = 8'h10 + 8'(k);
      b1 = 8'h20 + 8'(k);
      b2 = 8'h30 + 8'(k);
      b3 = 8'h80 + 8'(k);
      checks++;
      if (log_re[base + k] !== {4'h0, b2, b0, 8'h00} || log_im[base + k] !== {4'hF, b3, b1, 8'h00}) begin
        errors++;
        $display("FAIL frame_data%0d: re=%h im=%h, required %h %h", k,
                 log_re[base + k], log_im[base + k], {4'h0, b2, b0, 8'h00}, {4'hF, b3, b1, 8'h00});
      end
    end
    checks++;
    if (dut.state !== 2'd0 || dut.sample_cnt !== '0) begin
      errors++;
      $display("FAIL frame_idle: state=%0d sample_cnt=%0d, required 0/0", dut.state, dut.sample_cnt);
    end
  endtask

  task automatic test_backpressure();
    int early;
    do_reset();
    ready_i = 1'b0;
    early = 0;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h7F);
    send_byte(8'hFE);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) send_byte(8'h99);
      else @(negedge clk);
      if (valid_o) early++;
    end
    checks++;
    if (early !== 0 || dut.state !== 2'd2) begin
      errors++;
      $display("FAIL bp_hold: early valids=%0d state=%0d, required 0/2", early, dut.state);
    end
    checks++;
    if (overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_overrun_set: overrun=%b, required 1", overrun_o);
    end
    ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b1 || data_re_o !== 28'h07F0100 || data_im_o !== 28'hFFE0200) begin
      errors++;
      $display("FAIL bp_release: valid=%b re=%h im=%h, required 1 %h %h",
               valid_o, data_re_o, data_im_o, 28'h07F0100, 28'hFFE0200);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_overrun_sticky: overrun=%b, required 1", overrun_o);
    end
    do_reset();
    checks++;
    if (overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_overrun_clear: overrun=%b, required 0", overrun_o);
    end
  endtask

  task automatic test_timeout();
    int base;
    int to0;
    int early_to;
    do_reset();
    ready_i = 1'b1;
    send_sample(8'h01, 8'h02, 8'h03, 8'h04);
    send_byte(8'hAA);
    send_byte(8'hBB);
    to0 = n_timeout;
    early_to = 0;
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      if (timeout_o) early_to++;
    end
    @(negedge clk);
    checks++;
    if (early_to !== 0 || timeout_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse: early=%0d timeout=%b valid=%b, required 0/1/0",
               early_to, timeout_o, valid_o);
    end
    checks++;
    if (dut.sample_cnt !== 2'd1 || dut.byte_cnt !== 2'd0) begin
      errors++;
      $display("FAIL to_counters: sample_cnt=%0d byte_cnt=%0d, required 1/0",
               dut.sample_cnt, dut.byte_cnt);
    end
    base = log_n;
    send_sample(8'h55, 8'h66, 8'h12, 8'h34);
    @(negedge clk);
    checks++;
    if (log_n - base !== 1 || log_re[base] !== 28'h0125500 || log_im[base] !== 28'h0346600) begin
      errors++;
      $display("FAIL to_new_sample: pulses=%0d re=%h im=%h, required 1 %h %h",
               log_n - base, log_re[base], log_im[base], 28'h0125500, 28'h0346600);
    end
    checks++;
    if (n_timeout - to0 !== 1 || dut.sample_cnt !== 2'd2) begin
      errors++;
      $display("FAIL to_once: timeouts=%0d sample_cnt=%0d, required 1/2",
               n_timeout - to0, dut.sample_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int done0;
    do_reset();
    ready_i = 1'b1;
    send_sample(8'h0A, 8'h0B, 8'h0C, 8'h0D);
    send_byte(8'hE1);
    send_byte(8'hE2);
    send_byte(8'hE3);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (data_re_o !== '0 || data_im_o !== '0 || valid_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: re=%h im=%h valid=%b done=%b, required 0",
               data_re_o, data_im_o, valid_o, done_o);
    end
    checks++;
    if (dut.state !== 2'd0 || dut.byte_cnt !== 2'd0 || dut.sample_cnt !== '0) begin
      errors++;
      $display("FAIL mid_reset_state: state=%0d byte_cnt=%0d sample_cnt=%0d, required 0",
               dut.state, dut.byte_cnt, dut.sample_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    base  = log_n;
    done0 = n_done;
    send_sample(8'h40, 8'h41, 8'h42, 8'h43);
    send_sample(8'h50, 8'h51, 8'h52, 8'h53);
    send_sample(8'h60, 8'h61, 8'h62, 8'h63);
    send_sample(8'h70, 8'h71, 8'hF2, 8'h73);
    @(negedge clk);
    checks++;
    if (log_n - base !== NP || n_done - done0 !== 1 || log_done[base + NP - 1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame: pulses=%0d dones=%0d last_done=%b, required %0d/1/1",
               log_n - base, n_done - done0, log_done[base + NP - 1], NP);
    end
    checks++;
    if (log_re[base] !== 28'h0424000 || log_im[base] !== 28'h0434100) begin
      errors++;
      $display("FAIL mid_first_data: re=%h im=%h, required %h %h",
               log_re[base], log_im[base], 28'h0424000, 28'h0434100);
    end
    checks++;
    if (log_re[base + 3] !== 28'hFF27000 || log_im[base + 3] !== 28'h0737100) begin
      errors++;
      $display("FAIL mid_last_data: re=%h im=%h, required %h %h",
               log_re[base + 3], log_im[base + 3], 28'hFF27000, 28'h0737100);
    end
  endtask

  initial begin
    rst_n   = 1'b1;
    en_i    = 1'b0;
    data_in = 8'h00;
    ready_i = 1'b1;
    test_reset();
    test_single();
    test_frame();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
